// File: rtl/fixed_point_divider_hs_pkg.sv
// Shared types and constants for the handshaked fixed-point divider.
package fxp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [63:0] sat_pos(input int w);
    sat_pos = (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int w);
    sat_neg = 64'd1 << (w - 1);
  endfunction

  // Number of quotient bits produced by the shift/subtract loop.
  function automatic int nb(input int w, input int f, input int r);
    nb = w + f + r;
  endfunction

endpackage

// File: rtl/fixed_point_divider_hs_if.sv
// Operand/result valid-ready bundle between the solver datapath and the divider.
interface fixed_point_divider_hs_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, overflow, div_by_zero
  );
endinterface

// File: rtl/carry_select_adder.sv
// Two-segment carry-select adder/subtractor; o_cout=1 on subtract means no borrow.
module carry_select_adder #(parameter int N = 17) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_is_subtract,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);
  localparam int LO = N / 2;
  localparam int HI = N - LO;

  logic [N-1:0] w_b;
  logic [LO:0]  w_lo;
  logic [HI:0]  w_hi0;
  logic [HI:0]  w_hi1;

  assign w_b   = i_is_subtract ? ~i_b : i_b;
  assign w_lo  = {1'b0, i_a[LO-1:0]} + {1'b0, w_b[LO-1:0]} + {{LO{1'b0}}, i_is_subtract};
  assign w_hi0 = {1'b0, i_a[N-1:LO]} + {1'b0, w_b[N-1:LO]};
  assign w_hi1 = {1'b0, i_a[N-1:LO]} + {1'b0, w_b[N-1:LO]} + {{HI{1'b0}}, 1'b1};

  assign {o_cout, o_sum[N-1:LO]} = w_lo[LO] ? w_hi1 : w_hi0;
  assign o_sum[LO-1:0]           = w_lo[LO-1:0];
endmodule

// File: rtl/fixed_point_divider_hs_step.sv
// One restoring-division step: shift in a numerator bit, trial-subtract the divisor.
module fxp_div_step #(parameter int WIDTH = 16) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_nbit,
  input  logic [WIDTH-1:0] i_den,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_no_borrow;

  assign w_shift = {i_rem[WIDTH-1:0], i_nbit};

  carry_select_adder #(.N(WIDTH + 1)) u_sub (
    .i_a           (w_shift),
    .i_b           ({1'b0, i_den}),
    .i_is_subtract (1'b1),
    .o_sum         (w_diff),
    .o_cout        (w_no_borrow)
  );

  // A bit shifted out of the top means the true partial remainder exceeds any divisor.
  assign o_qbit = i_rem[WIDTH] | w_no_borrow;
  assign o_rem  = o_qbit ? w_diff : w_shift;
endmodule

// File: rtl/fixed_point_divider_hs.sv
// Signed fixed-point restoring divider with valid/ready handshakes, rounding and saturation.
module fixed_point_divider_hs
  import fxp_div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ROUND = 0
) (
  input logic                     clk,
  input logic                     rst,
  fixed_point_divider_hs_if.slave bus
);
  localparam int NBITS = nb(WIDTH, FRAC, ROUND);
  localparam int CW    = $clog2(NBITS);
  localparam int MW    = NBITS + 1;
  localparam logic [WIDTH-1:0] SAT_P = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_N = WIDTH'(sat_neg(WIDTH));

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sign;
  logic             r_dz;
  logic             r_dvd_neg;
  logic [WIDTH-1:0] r_den;
  logic [NBITS-1:0] r_num;
  logic [NBITS-1:0] r_q;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic             r_ovf;
  logic             r_dzf;
  logic             r_out_valid;

  logic             w_accept;
  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_qbit;
  logic [MW-1:0]    w_mag;
  logic [MW-1:0]    w_limit;
  logic [WIDTH-1:0] w_quot_fix;
  logic             w_ovf_fix;

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quot;
  assign bus.overflow    = r_ovf;
  assign bus.div_by_zero = r_dzf;

  assign w_accept  = bus.in_valid & (r_state == IDLE);
  assign w_abs_dvd = bus.dividend[WIDTH-1] ? ({WIDTH{1'b0}} - bus.dividend) : bus.dividend;
  assign w_abs_dvs = bus.divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - bus.divisor)  : bus.divisor;

  fxp_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_nbit (r_num[NBITS-1]),
    .i_den  (r_den),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)        w_state_nxt = CALC; else w_state_nxt = IDLE;
      CALC:    if (r_cnt == {CW{1'b0}}) w_state_nxt = FIX;  else w_state_nxt = CALC;
      FIX:     w_state_nxt = DONE;
      DONE:    if (bus.out_ready)       w_state_nxt = IDLE; else w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Rounding, range limiting and divide-by-zero override of the raw quotient
  always_comb begin
    if (ROUND != 0) w_mag = {2'b00, r_q[NBITS-1:1]} + {{NBITS{1'b0}}, r_q[0]};
    else            w_mag = {1'b0, r_q};
    w_limit    = r_sign ? MW'(SAT_N) : MW'(SAT_P);
    w_ovf_fix  = 1'b0;
    w_quot_fix = {WIDTH{1'b0}};
    if (r_dz) begin
      w_quot_fix = r_dvd_neg ? SAT_N : SAT_P;
    end else if (w_mag > w_limit) begin
      w_ovf_fix  = 1'b1;
      w_quot_fix = r_sign ? SAT_N : SAT_P;
    end else begin
      w_quot_fix = r_sign ? ({WIDTH{1'b0}} - w_mag[WIDTH-1:0]) : w_mag[WIDTH-1:0];
    end
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sign      <= 1'b0;
      r_dz        <= 1'b0;
      r_dvd_neg   <= 1'b0;
      r_den       <= {WIDTH{1'b0}};
      r_num       <= {NBITS{1'b0}};
      r_q         <= {NBITS{1'b0}};
      r_rem       <= {(WIDTH + 1){1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_quot      <= {WIDTH{1'b0}};
      r_ovf       <= 1'b0;
      r_dzf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          // Zero dividend forces a positive sign so the result is never -0.
          r_sign    <= (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]) & (|bus.dividend);
          r_dvd_neg <= bus.dividend[WIDTH-1];
          r_dz      <= ~(|bus.divisor);
          r_den     <= w_abs_dvs;
          r_num     <= NBITS'(w_abs_dvd) << (FRAC + ROUND);
          r_q       <= {NBITS{1'b0}};
          r_rem     <= {(WIDTH + 1){1'b0}};
          r_cnt     <= CW'(NBITS - 1);
          r_ovf     <= 1'b0;
          r_dzf     <= 1'b0;
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[NBITS-2:0], w_qbit};
          r_num <= {r_num[NBITS-2:0], 1'b0};
          r_cnt <= r_cnt - {{(CW - 1){1'b0}}, 1'b1};
        end
        FIX: begin
          r_quot      <= w_quot_fix;
          r_ovf       <= w_ovf_fix;
          r_dzf       <= r_dz;
          r_out_valid <= 1'b1;
        end
        DONE: if (bus.out_ready) r_out_valid <= 1'b0;
        default: r_out_valid <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_point_divider_hs.sv
// Drives truncating and rounding Q8.8 dividers side by side against an arithmetic model.
module tb_fixed_point_divider_hs;
  localparam int W    = 16;
  localparam int F    = 8;
  localparam int LAT0 = W + F + 0 + 2;
  localparam int LAT1 = W + F + 1 + 2;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fixed_point_divider_hs_if #(.WIDTH(W)) bus0 ();
  fixed_point_divider_hs_if #(.WIDTH(W)) bus1 ();

  fixed_point_divider_hs #(.WIDTH(W), .FRAC(F), .ROUND(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fixed_point_divider_hs #(.WIDTH(W), .FRAC(F), .ROUND(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    bus0.in_valid = v; bus0.dividend = a; bus0.divisor = b;
    bus1.in_valid = v; bus1.dividend = a; bus1.divisor = b;
  endtask

  // Real-valued division scaled by 2^F, then clamped to the signed 16-bit range.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input int rnd,
                                output logic [W-1:0] q, output logic ovf, output logic dz);
    longint sa, sb, ma, mb, mag, val;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      dz = 1'b1; ovf = 1'b0;
      q  = (sa >= 0) ? 16'h7FFF : 16'h8000;
    end else begin
      dz  = 1'b0;
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sb < 0) ? -sb : sb;
      if (rnd != 0) mag = (2 * ma * (64'sd1 << F) + mb) / (2 * mb);
      else          mag = (ma * (64'sd1 << F)) / mb;
      val = ((sa < 0) != (sb < 0)) ? -mag : mag;
      if (val > 32767)       begin q = 16'h7FFF; ovf = 1'b1; end
      else if (val < -32768) begin q = 16'h8000; ovf = 1'b1; end
      else                   begin q = val[15:0]; ovf = 1'b0; end
    end
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq0, eq1, q0, q1;
    logic eo0, eo1, ez0, ez1, o0, o1, z0, z1;
    int c0, c1;
    model(a, b, 0, eq0, eo0, ez0);
    model(a, b, 1, eq1, eo1, ez1);
    check($sformatf("in_ready0 %h/%h", a, b), {31'd0, bus0.in_ready}, 32'd1);
    check($sformatf("in_ready1 %h/%h", a, b), {31'd0, bus1.in_ready}, 32'd1);
    set_in(1'b1, a, b);
    @(posedge clk); #1;
    set_in(1'b0, 16'($urandom), 16'($urandom));
    c0 = 0; c1 = 0;
    q0 = 'x; q1 = 'x; o0 = 1'bx; o1 = 1'bx; z0 = 1'bx; z1 = 1'bx;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (c0 == 0 && bus0.out_valid) begin
        c0 = cyc; q0 = bus0.quotient; o0 = bus0.overflow; z0 = bus0.div_by_zero;
      end
      if (c1 == 0 && bus1.out_valid) begin
        c1 = cyc; q1 = bus1.quotient; o1 = bus1.overflow; z1 = bus1.div_by_zero;
      end
      if (c0 != 0 && c1 != 0) break;
      @(posedge clk); #1;
    end
    check($sformatf("lat0 %h/%h", a, b), c0, LAT0);
    check($sformatf("lat1 %h/%h", a, b), c1, LAT1);
    check($sformatf("quot0 %h/%h", a, b), {16'd0, q0}, {16'd0, eq0});
    check($sformatf("quot1 %h/%h", a, b), {16'd0, q1}, {16'd0, eq1});
    check($sformatf("ovf0 %h/%h", a, b), {31'd0, o0}, {31'd0, eo0});
    check($sformatf("ovf1 %h/%h", a, b), {31'd0, o1}, {31'd0, eo1});
    check($sformatf("dz0 %h/%h", a, b), {31'd0, z0}, {31'd0, ez0});
    check($sformatf("dz1 %h/%h", a, b), {31'd0, z1}, {31'd0, ez1});
    @(posedge clk); #1;
    check("consumed0", {31'd0, bus0.out_valid}, 32'd0);
    check("consumed1", {31'd0, bus1.out_valid}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b0;
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    set_in(1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", {31'd0, bus0.out_valid}, 32'd0);
    check("rst quotient", {16'd0, bus0.quotient}, 32'd0);
    check("rst overflow", {31'd0, bus0.overflow}, 32'd0);
    check("rst div_by_zero", {31'd0, bus0.div_by_zero}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post-rst in_ready", {31'd0, bus0.in_ready}, 32'd1);

    // Directed cases: nominal, signs, rounding, saturation, divide by zero.
    run_op(16'h0300, 16'h0200);
    run_op(16'hF880, 16'h0280);
    run_op(16'h0100, 16'hFD00);
    run_op(16'h0200, 16'h0300);
    run_op(16'h0100, 16'h0300);
    run_op(16'h6400, 16'h0080);
    run_op(16'h8000, 16'h0100);
    run_op(16'h8000, 16'hFF00);
    run_op(16'h0500, 16'h0000);
    run_op(16'hFB00, 16'h0000);
    run_op(16'h0000, 16'hFD00);
    run_op(16'h0000, 16'h0000);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if (i % 3 == 0) rb = {{8{rb[15]}}, rb[7:0]};
      run_op(ra, rb);
    end

    // Back-pressure: result must hold while out_ready is low.
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    set_in(1'b1, 16'h0300, 16'h0200);
    @(posedge clk); #1;
    set_in(1'b0, 16'h1234, 16'h0001);
    for (int i = 0; i < 60 && !(bus0.out_valid && bus1.out_valid); i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      check("hold out_valid", {31'd0, bus0.out_valid}, 32'd1);
      check("hold quotient", {16'd0, bus0.quotient}, 32'h0180);
      check("hold quotient rnd", {16'd0, bus1.quotient}, 32'h0180);
      check("hold in_ready", {31'd0, bus0.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release out_valid0", {31'd0, bus0.out_valid}, 32'd0);
    check("release out_valid1", {31'd0, bus1.out_valid}, 32'd0);
    check("bubble in_ready", {31'd0, bus0.in_ready}, 32'd1);

    // Reset in the middle of an iteration aborts it.
    set_in(1'b1, 16'h0500, 16'h0100);
    @(posedge clk); #1;
    set_in(1'b0, 16'h0000, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    check("midcalc in_ready", {31'd0, bus0.in_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort out_valid0", {31'd0, bus0.out_valid}, 32'd0);
    check("abort in_ready0", {31'd0, bus0.in_ready}, 32'd1);
    check("abort out_valid1", {31'd0, bus1.out_valid}, 32'd0);
    check("abort in_ready1", {31'd0, bus1.in_ready}, 32'd1);
    run_op(16'h0500, 16'h0100);
    run_op(16'hFE80, 16'h0040);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
